// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around alu_share_arbiter.
// master = sequencers/ALU/consumer side, slave = the arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_data, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_data, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight,
// result returned with a requester tag over a valid/ready response channel.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q;
    logic             tag_q;
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic winner;
    logic accept;

    // Pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ptr_q;
        end else begin
            winner = bus.req1_valid;
        end
    end

    assign accept         = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !winner;
    assign bus.req1_ready = accept && winner;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            tag_q      <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_op_q <= winner ? bus.req1_op : bus.req0_op;
                alu_a_q  <= winner ? bus.req1_a  : bus.req0_a;
                alu_b_q  <= winner ? bus.req1_b  : bus.req0_b;
                tag_q    <= winner;
                ptr_q    <= ~winner;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= bus.alu_result;
                rsp_id_q   <= tag_q;
            end
        end
    end

    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    // HOLD is entered exactly at the edge that captures the result.
    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
